// File: rtl/uart_tx_buffered_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered_if
// Purpose  : Host-side byte interface and status/serial signals of the
//            buffered UART transmitter.
// Revision : 1.0  initial release
// ============================================================================
interface uart_tx_buffered_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [7:0]          data;
  logic                write;
  logic                full;
  logic                empty;
  logic [ADDR_WIDTH:0] count;
  logic                busy;
  logic                overflow;
  logic                tx_o;

  // Host side: supplies bytes, observes status and the serial line
  modport master (
    output data, write,
    input  full, empty, count, busy, overflow, tx_o
  );

  // Transmitter side
  modport slave (
    input  data, write,
    output full, empty, count, busy, overflow, tx_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered
// Purpose  : UART transmitter with an internal byte FIFO and baud counter.
//            Queued bytes are sent back-to-back, LSB first, start/stop framed.
//            Optional feature macro UART_TX_PARITY_EN adds an even-sense
//            parity bit (XOR of the byte) between data and stop (8E1);
//            without it the frame is 8N1.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_WIDTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_buffered_if.slave  bus
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0]     BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  // Registered state
  state_t                state_q, state_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [7:0]            shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  logic [7:0]            mem_q [FIFO_DEPTH];

  logic                  full;
  logic                  empty;
  logic                  bit_done;
  logic                  push;
  logic                  pop;
  logic [7:0]            head;

  assign full  = (count_q == COUNT_FULL);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Next-state logic: FIFO bookkeeping, baud timing, frame sequencing and
  // the value tx_o will carry in the state being entered.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    pop        = 1'b0;
    push       = 1'b0;
    tx_d       = 1'b1;

    bit_done = (state_q != IDLE) && (baud_q == BAUD_LAST);

    // Baud counter runs only while a frame is active
    if (state_q == IDLE || bit_done) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BAUD_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef UART_TX_PARITY_EN
          parity_d = ^head;
`endif
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          // Chain straight into the next frame when data is waiting
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
`ifdef UART_TX_PARITY_EN
            parity_d = ^head;
`endif
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A pop in the same cycle frees a slot, so a write while full still lands
    push = bus.write && (!full || pop);
    if (bus.write && full && !pop) begin
      overflow_d = 1'b1;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase

    // Serial line value for the state about to be entered
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and discards queued bytes
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= bus.data;
    end
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.busy     = (state_q != IDLE);
  assign bus.overflow = overflow_q;
  assign bus.tx_o     = tx_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffered
// Purpose  : Directed self-checking bench for uart_tx_buffered
//            (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  uart_tx_buffered_if #(.ADDR_WIDTH(AW)) bus ();

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Frame bit idx: 0 start, 1..8 data LSB first, then parity (if built), stop
  function automatic logic frame_bit(input logic [7:0] b, input logic par, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && NB == 11) return par;
    return 1'b1;
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    bus.write = 1'b0;
    bus.data  = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following the sampling edge
  task automatic write1(input logic [7:0] b);
    bus.data  = b;
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  // Entered at cycle 2 of bit 'first'; checks each remaining bit mid-bit
  task automatic recv_body(input logic [7:0] b, input logic par, input int first);
    for (int i = first; i < NB; i++) begin
      if (i != first) repeat (CPB) @(negedge clk);
      chk($sformatf("bit%0d_of_%02h", i, b), bus.tx_o, frame_bit(b, par, i));
    end
  endtask

  // Waits for a start bit, checking the number of cycles it took to appear
  task automatic recv_frame(input logic [7:0] b, input logic par, input int exp_gap);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tx_o !== 1'b0 && n < 400);
    chk($sformatf("start_gap_%02h", b), n, exp_gap);
    if (bus.tx_o === 1'b0) begin
      repeat (2) @(negedge clk);
      recv_body(b, par, 0);
    end
  endtask

  initial begin
    automatic logic [7:0] ovf_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    automatic int         ovf_cnt   [5] = '{1, 2, 3, 4, 4};
    automatic logic [7:0] ful_bytes [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    int peak;
    int zeros;

    bus.write = 1'b0;
    bus.data  = 8'h00;

    // ---- reset state and idle line ----
    do_reset();
    chk("rst_full", bus.full, 1'b0);
    chk("rst_overflow", bus.overflow, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idle_status", {bus.tx_o, bus.busy, bus.empty, bus.count}, {1'b1, 1'b0, 1'b1, 3'd0});
    end

    // ---- single byte A5, latency and frame length ----
    write1(8'hA5);
    chk("a5_count", bus.count, 3'd1);
    chk("a5_empty", bus.empty, 1'b0);
    chk("a5_busy_pre", bus.busy, 1'b0);
    recv_frame(8'hA5, 1'b0, 1);
    @(negedge clk);
    chk("a5_busy_last", bus.busy, 1'b1);
    @(negedge clk);
    chk("a5_busy_end", bus.busy, 1'b0);
    chk("a5_tx_idle", bus.tx_o, 1'b1);
    chk("a5_empty_end", bus.empty, 1'b1);

    // ---- burst of three bytes, back-to-back frames ----
    do_reset();
    peak = 0;
    bus.data = 8'h01; bus.write = 1'b1;
    @(negedge clk); if (int'(bus.count) > peak) peak = int'(bus.count);
    bus.data = 8'h80;
    @(negedge clk); if (int'(bus.count) > peak) peak = int'(bus.count);
    bus.data = 8'hFF;
    @(negedge clk); if (int'(bus.count) > peak) peak = int'(bus.count);
    bus.write = 1'b0;
    chk("burst_peak", peak, 2);
    @(negedge clk);
    recv_body(8'h01, 1'b1, 0);
    recv_frame(8'h80, 1'b1, 2);
    recv_frame(8'hFF, 1'b0, 2);
    repeat (2) @(negedge clk);
    chk("burst_busy_end", bus.busy, 1'b0);
    chk("burst_empty_end", bus.empty, 1'b1);

    // ---- overflow: one in flight, five more writes into a 4-deep FIFO ----
    do_reset();
    write1(8'hB0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      bus.data  = ovf_bytes[i];
      bus.write = 1'b1;
      @(negedge clk);
      chk($sformatf("ovf_count%0d", i), bus.count, ovf_cnt[i]);
      chk($sformatf("ovf_full%0d", i), bus.full, (i >= 3) ? 1'b1 : 1'b0);
      chk($sformatf("ovf_flag%0d", i), bus.overflow, (i == 4) ? 1'b1 : 1'b0);
    end
    bus.write = 1'b0;
    recv_body(8'hB0, 1'b1, 1);
    recv_frame(8'h11, 1'b0, 2);
    recv_frame(8'h22, 1'b0, 2);
    recv_frame(8'h33, 1'b0, 2);
    recv_frame(8'h44, 1'b0, 2);
    repeat (2) @(negedge clk);
    chk("ovf_busy_end", bus.busy, 1'b0);
    zeros = 0;
    for (int i = 0; i < 3 * NB * CPB; i++) begin
      @(negedge clk);
      if (bus.tx_o !== 1'b1) zeros++;
    end
    chk("ovf_no_sixth_frame", zeros, 0);
    chk("ovf_sticky", bus.overflow, 1'b1);
    do_reset();
    chk("ovf_cleared", bus.overflow, 1'b0);

    // ---- write while full on the STOP pop edge ----
    write1(8'hA0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.data  = ful_bytes[i];
      bus.write = 1'b1;
      @(negedge clk);
    end
    bus.write = 1'b0;
    chk("ful_count", bus.count, 3'd4);
    chk("ful_full", bus.full, 1'b1);
    @(negedge clk);
    recv_body(8'hA0, 1'b0, 1);
    @(negedge clk);
    bus.data  = 8'hC5;
    bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
    chk("ful_pop_count", bus.count, 3'd4);
    chk("ful_pop_overflow", bus.overflow, 1'b0);
    chk("ful_pop_full", bus.full, 1'b1);
    repeat (2) @(negedge clk);
    recv_body(8'hC1, 1'b1, 0);
    recv_frame(8'hC2, 1'b1, 2);
    recv_frame(8'hC3, 1'b0, 2);
    recv_frame(8'hC4, 1'b1, 2);
    recv_frame(8'hC5, 1'b0, 2);
    repeat (2) @(negedge clk);
    chk("ful_empty_end", bus.empty, 1'b1);

    // ---- reset in the middle of data bit 3 ----
    do_reset();
    write1(8'hC3);
    write1(8'h5A);
    repeat (17) @(negedge clk);
    chk("mid_tx_pre", bus.tx_o, 1'b0);
    chk("mid_busy_pre", bus.busy, 1'b1);
    chk("mid_count_pre", bus.count, 3'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_tx_post", bus.tx_o, 1'b1);
    chk("mid_busy_post", bus.busy, 1'b0);
    chk("mid_count_post", bus.count, 3'd0);
    reset = 1'b0;
    zeros = 0;
    for (int i = 0; i < 15 * CPB; i++) begin
      @(negedge clk);
      if (bus.tx_o !== 1'b1 || bus.busy !== 1'b0) zeros++;
    end
    chk("mid_quiet_after", zeros, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
